// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display with a
// valid/ready load port. Build option: SEVEN_SEG_LZ_BLANK_EN blanks leading zeros.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic [NUM_DIGITS-1:0]   i_Dp,
    input  logic                    i_Load,
    output logic                    o_Ready,
    output logic [NUM_DIGITS-1:0]   o_Anode,
    output logic [6:0]              o_Segment,
    output logic                    o_Dp,
    output logic                    o_Frame_Tick
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]              state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [4*NUM_DIGITS-1:0] disp_val, disp_val_n, shadow_val;
    logic [NUM_DIGITS-1:0]   disp_dp, disp_dp_n, shadow_dp;
    logic                    boundary;
    logic                    accept;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [3:0]              nib_n;
    logic                    lead_blank_n;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h08;
            4'hB:    decode = 7'h03;
            4'hC:    decode = 7'h46;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        boundary = 1'b0;
        case (state)
            ST_BLANK: begin
                if (GUARD_CYCLES == 0 || cnt == GUARD_LAST) begin
                    state_n = ST_DRIVE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    cnt_n    = '0;
                    boundary = (idx == IDX_LAST);
                    idx_n    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    state_n  = (GUARD_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_BLANK;
                cnt_n   = '0;
            end
        endcase
    end

    // o_Ready low means the shadow holds an update not yet on display
    assign accept     = i_Load && o_Ready;
    assign commit     = boundary && !o_Ready;
    assign disp_val_n = commit ? shadow_val : disp_val;
    assign disp_dp_n  = commit ? shadow_dp  : disp_dp;

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] hi_zero;
    always_comb begin
        logic        run;
        int unsigned k;
        hi_zero = '0;
        run     = 1'b1;
        k       = 0;
        // hi_zero[k]: every nibble from k up to the top digit is zero
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            k          = NUM_DIGITS - 1 - i;
            run        = run && (disp_val_n[4*k +: 4] == 4'h0);
            hi_zero[k] = run;
        end
        lead_blank_n = (idx_n != '0) && hi_zero[idx_n];
    end
`else
    assign lead_blank_n = 1'b0;
`endif

    // Outputs are registered from next-state values so pins line up with the FSM state
    always_comb begin
        anode_n = '1;
        seg_n   = 7'h7F;
        dp_n    = 1'b1;
        nib_n   = disp_val_n[4*idx_n +: 4];
        if (state_n == ST_DRIVE) begin
            anode_n[idx_n] = 1'b0;
            seg_n          = lead_blank_n ? 7'h7F : decode(nib_n);
            dp_n           = ~disp_dp_n[idx_n];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state        <= ST_BLANK;
            cnt          <= '0;
            idx          <= '0;
            disp_val     <= '0;
            disp_dp      <= '0;
            shadow_val   <= '0;
            shadow_dp    <= '0;
            o_Ready      <= 1'b1;
            o_Anode      <= '1;
            o_Segment    <= 7'h7F;
            o_Dp         <= 1'b1;
            o_Frame_Tick <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            disp_val <= disp_val_n;
            disp_dp  <= disp_dp_n;
            if (accept) begin
                shadow_val <= i_Value;
                shadow_dp  <= i_Dp;
            end
            if (commit) begin
                o_Ready <= 1'b1;
            end else if (accept) begin
                o_Ready <= 1'b0;
            end
            o_Anode      <= anode_n;
            o_Segment    <= seg_n;
            o_Dp         <= dp_n;
            o_Frame_Tick <= boundary;
        end
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It accepts a packed hex value plus decimal points through a valid/ready load handshake. It cycles one digit at a time: anode enable, hex-to-segment decode, and a guard blanking interval between digits to suppress ghosting. It sits between the value source (counters, VGA debug registers) and the board display pins. New values are committed only at frame boundaries, so a partially updated frame is never shown.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 100000, i_Clk cycles each digit is driven (>=1)
GUARD_CYCLES, 1000, i_Clk cycles of all-anodes-off between digits (0 = no guard interval)

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous reset, active-high
i_Value  in  4*NUM_DIGITS  packed nibbles; nibble k ([4k+3:4k]) shown on digit k
i_Dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
i_Load  in  1  load request; qualified by o_Ready
o_Ready  out  1  high when no update is pending
o_Anode  out  NUM_DIGITS  digit enables, active-low
o_Segment  out  7  segments GFEDCBA, active-low
o_Dp  out  1  decimal point, active-low
o_Frame_Tick  out  1  one-cycle pulse when digit NUM_DIGITS-1 finishes

Behaviour:
- Interface: one clock; reset is synchronous and active-high (i_Clk, i_Reset).
- Reset values:
  - o_Anode all 1s, o_Segment 7'h7F, o_Dp 1, o_Ready 1, o_Frame_Tick 0.
  - Display and shadow registers 0, digit index 0, counters 0, state BLANK.
- All outputs are registered.
- Handshake:
  - Accept when i_Load && o_Ready. i_Value/i_Dp are captured into the shadow register; o_Ready drops the next cycle.
  - i_Load while o_Ready=0 is ignored, and the shadow register is unchanged.
- Commit: on the cycle DRIVE of digit NUM_DIGITS-1 ends, if an update is pending:
  - shadow is copied to the display register; o_Ready rises the next cycle.
  - A load accepted in that same boundary cycle is captured but committed at the following boundary.
- FSM:
  - BLANK: anodes all off, segments 7F, Dp off. Hold GUARD_CYCLES cycles, then go to DRIVE.
  - DRIVE: o_Anode[idx]=0, others 1. o_Segment = decode(display nibble idx); o_Dp = ~display_dp[idx]. Hold REFRESH_DIV cycles.
  - On DRIVE exit, idx increments, wrapping from NUM_DIGITS-1 to 0. Go to BLANK, or directly to DRIVE if GUARD_CYCLES=0.
  - o_Frame_Tick pulses on the cycle after the wrap.
  - NUM_DIGITS=1: every DRIVE exit is a frame boundary.
- Decode (active-low GFEDCBA):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Counter widths: sized by $clog2 of the parameters; counters never overflow.
- Reset mid-frame: returns to the reset state at once and drops any pending update.

Optional Feature:
SEVEN_SEG_LZ_BLANK_EN
- Defined: digits above the most significant nonzero nibble of the display register show segments 7F while the anode still scans. Digit 0 always shows its value (value 0 shows "0"). Dp is unaffected.
- Undefined: all digits are decoded, and leading zeros are shown.

Test Plan:
1. Reset (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1) -> anodes 4'hF and segments 7F on the first cycle after reset. The scan then shows 1 blank + 4 drive cycles per digit, and digit 0 shows 7'h40.
2. Load 16'h12AF with i_Dp=4'b0100 mid-frame -> o_Ready drops; the old value finishes the frame. After o_Frame_Tick, the sequence is digit0=0E, digit1=08, digit2=24 with o_Dp=0, digit3=79.
3. i_Load held while o_Ready=0 with 16'hFFFF -> ignored; the committed value remains 16'h12AF.
4. Load asserted in the exact boundary cycle -> the value is committed one frame later; o_Ready is low for one full frame.
5. GUARD_CYCLES=0 -> o_Anode moves directly E→D→B→7, never all-1s after reset.
6. With SEVEN_SEG_LZ_BLANK_EN, load 16'h0050 -> digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40. Load 0 -> only digit 0 shows 40.
